// File: rtl/shift_seq_ctrl_pkg.sv
// Shared constants, state encoding and job context for the iterative shift sequencer.
package shift_seq_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] SHOP_SLL = 2'b00;
  localparam logic [OP_W-1:0] SHOP_SRL = 2'b01;
  localparam logic [OP_W-1:0] SHOP_SRA = 2'b11;
  localparam logic [OP_W-1:0] SHOP_ILL = 2'b10;

  localparam logic AMT_RS    = 1'b0;
  localparam logic AMT_SHAMT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Context captured on accept and iterated during SHIFT.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              sign;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] work;
  } job_t;

  // Bits to shift this cycle: never overshoot the remaining count.
  function automatic logic [CNT_W-1:0] step_amt(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] step);
    return (cnt < step) ? cnt : step;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_step.sv
// Combinational single-step shifter: shifts work by k bits with op-dependent fill.
module shift_step
  import shift_seq_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] work_i,
  input  logic [CNT_W-1:0]  k_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] work_c_o
);

  always_comb begin
    work_c_o = work_i;
    case (op_i)
      SHOP_SLL: work_c_o = work_i << k_i;
      SHOP_SRL: work_c_o = work_i >> k_i;
      // Arithmetic fill uses the sign captured at accept, not the current MSB.
      SHOP_SRA: work_c_o = sign_i ? ~((~work_i) >> k_i) : (work_i >> k_i);
      default:  work_c_o = work_i;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: captures an operand/amount on start and shifts STEP bits per cycle.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   shift_op,
  input  logic              amt_sel,
  input  logic [CNT_W-1:0]  shamt,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              flush,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  state_e            state_q, state_d;
  job_t              job_q, job_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;
  logic              ready_q, done_q;
  logic              accept;
  logic [CNT_W-1:0]  amt_c;
  logic [CNT_W-1:0]  k_c;
  logic [DATA_W-1:0] step_work_c;
  logic              unused_rs_hi;

  // Variable shifts honour only the low five bits of rs.
  assign amt_c        = (amt_sel == AMT_SHAMT) ? shamt : rs_val[CNT_W-1:0];
  assign unused_rs_hi = ^rs_val[DATA_W-1:CNT_W];
  assign k_c          = step_amt(job_q.cnt, STEP_C);

  shift_step u_step (
    .work_i   (job_q.work),
    .k_i      (k_c),
    .op_i     (job_q.op),
    .sign_i   (job_q.sign),
    .work_c_o (step_work_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      job_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      result_q <= result_d;
      err_q    <= err_d;
      ready_q  <= (state_d != S_SHIFT);
      done_q   <= (state_d == S_DONE);
    end
  end

  // Next-state, capture and step logic; flush outranks start.
  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    result_d = result_q;
    err_d    = err_q;
    accept   = start && !flush && (state_q != S_SHIFT);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          job_d.work = rt_val;
          job_d.cnt  = amt_c;
          job_d.op   = shift_op;
          job_d.sign = rt_val[DATA_W-1];
          if (shift_op == SHOP_ILL) begin
            state_d  = S_DONE;
            result_d = rt_val;
            err_d    = 1'b1;
          end else if (amt_c == '0) begin
            state_d  = S_DONE;
            result_d = rt_val;
            err_d    = 1'b0;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          job_d.work = step_work_c;
          job_d.cnt  = job_q.cnt - k_c;
          if (job_q.cnt == k_c) begin
            state_d  = S_DONE;
            result_d = step_work_c;
            err_d    = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule
